// File: rtl/cnn_div_pkg.sv
// Shared widths and FSM encoding for the sequential 15/9 unsigned divider.
// Rounding build option: CNN_UDIV_ROUND_EN.
package cnn_div_pkg;

  localparam int DIVIDEND_W = 15;
  localparam int DIVISOR_W  = 9;
  localparam int CNT_W      = $clog2(DIVIDEND_W);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    RND,
    DONE
  } div_state_t;

endpackage

// File: rtl/cnn_udiv_step.sv
// One radix-2 restoring step: shift in a dividend bit,
// trial-subtract the divisor, keep the result if it fits.
module cnn_udiv_step
  import cnn_div_pkg::*;
#(
  parameter int DW = DIVISOR_W
) (
  input  logic [DW-1:0] i_rem,
  input  logic          i_bit,
  input  logic [DW-1:0] i_div,
  output logic [DW-1:0] o_rem,
  output logic          o_qbit
);

  logic [DW:0] w_part;

  assign w_part = {i_rem, i_bit};
  assign o_qbit = w_part >= {1'b0, i_div};

  // Result of a taken subtract is < divisor, so low DW bits suffice
  assign o_rem = o_qbit ? (w_part[DW-1:0] - i_div)
                        : w_part[DW-1:0];

endmodule

// File: rtl/cnn_udiv_15ns_9ns_seq.sv
// Sequential restoring divider, one quotient bit per cycle, valid/ready.
// Define CNN_UDIV_ROUND_EN to round the quotient half up.
module cnn_udiv_15ns_9ns_seq
  import cnn_div_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = DIVIDEND_W,
  parameter int DIVISOR_WIDTH  = DIVISOR_W
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic                      din_vld,
  output logic                      din_rdy,
  input  logic [DIVIDEND_WIDTH-1:0] din0,
  input  logic [DIVISOR_WIDTH-1:0]  din1,
  output logic                      dout_vld,
  input  logic                      dout_rdy,
  output logic [DIVIDEND_WIDTH-1:0] quot,
  output logic [DIVISOR_WIDTH-1:0]  rem,
  output logic                      dbz
);

  localparam int            CW   = $clog2(DIVIDEND_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DIVIDEND_WIDTH - 1);

  div_state_t                r_state;
  div_state_t                w_nxt;
  logic [DIVIDEND_WIDTH-1:0] r_q;
  logic [DIVISOR_WIDTH-1:0]  r_rem;
  logic [DIVISOR_WIDTH-1:0]  r_div;
  logic [CW-1:0]             r_cnt;
  logic                      r_dbz;
  logic [DIVISOR_WIDTH-1:0]  w_rem_nxt;
  logic                      w_qbit;
  logic                      w_acc;
  logic                      w_div0;

  assign w_acc  = din_vld & din_rdy;
  assign w_div0 = ~|din1;

  // r_q doubles as dividend shifter and quotient accumulator
  cnn_udiv_step #(
    .DW(DIVISOR_WIDTH)
  ) u_step (
    .i_rem (r_rem),
    .i_bit (r_q[DIVIDEND_WIDTH-1]),
    .i_div (r_div),
    .o_rem (w_rem_nxt),
    .o_qbit(w_qbit)
  );

`ifdef CNN_UDIV_ROUND_EN
  logic w_rnd_up;
  assign w_rnd_up = {r_rem, 1'b0} >= {1'b0, r_div};
`endif

  always_ff @(posedge ap_clk) begin
    if (ap_rst) r_state <= IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_acc) w_nxt = w_div0 ? DONE : CALC;
      end
      CALC: begin
`ifdef CNN_UDIV_ROUND_EN
        if (r_cnt == LAST) w_nxt = RND;
`else
        if (r_cnt == LAST) w_nxt = DONE;
`endif
      end
      RND: w_nxt = DONE;
      DONE: begin
        if (dout_rdy) w_nxt = IDLE;
      end
      default: w_nxt = IDLE;
    endcase
  end

  always_comb begin
    din_rdy  = (r_state == IDLE) & ~ap_rst;
    dout_vld = (r_state == DONE);
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_q   <= '0;
      r_rem <= '0;
      r_div <= '0;
      r_cnt <= '0;
      r_dbz <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_acc) begin
            r_div <= din1;
            r_cnt <= '0;
            if (w_div0) begin
              r_q   <= '1;
              r_rem <= din0[DIVISOR_WIDTH-1:0];
              r_dbz <= 1'b1;
            end else begin
              r_q   <= din0;
              r_rem <= '0;
              r_dbz <= 1'b0;
            end
          end
        end
        CALC: begin
          r_q   <= {r_q[DIVIDEND_WIDTH-2:0], w_qbit};
          r_rem <= w_rem_nxt;
          r_cnt <= r_cnt + 1'b1;
        end
`ifdef CNN_UDIV_ROUND_EN
        RND: begin
          if (w_rnd_up) r_q <= r_q + 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign quot = r_q;
  assign rem  = r_rem;
  assign dbz  = r_dbz;

endmodule

// File: tb/tb_cnn_udiv_15ns_9ns_seq.sv
// Scoreboard bench for cnn_udiv_15ns_9ns_seq: directed cases,
// back-pressure, reset abort and random ops vs a behavioural model.
module tb_cnn_udiv_15ns_9ns_seq;

  typedef struct packed {
    logic [14:0] q;
    logic [8:0]  r;
    logic        z;
  } res_t;

`ifdef CNN_UDIV_ROUND_EN
  localparam int RES_LAT = 17;
`else
  localparam int RES_LAT = 16;
`endif

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic        din_vld = 1'b0;
  logic        dout_rdy = 1'b0;
  logic [14:0] din0 = '0;
  logic [8:0]  din1 = '0;
  logic        din_rdy;
  logic        dout_vld;
  logic [14:0] quot;
  logic [8:0]  rem;
  logic        dbz;

  int   n_chk = 0;
  int   n_pass = 0;
  res_t sb[$];
  bit   g_imm = 1'b0;

  always #5 ap_clk = ~ap_clk;

  cnn_udiv_15ns_9ns_seq dut (
    .ap_clk  (ap_clk),
    .ap_rst  (ap_rst),
    .din_vld (din_vld),
    .din_rdy (din_rdy),
    .din0    (din0),
    .din1    (din1),
    .dout_vld(dout_vld),
    .dout_rdy(dout_rdy),
    .quot    (quot),
    .rem     (rem),
    .dbz     (dbz)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic res_t model(input logic [14:0] a, input logic [8:0] b);
    res_t e;
    int   ai, bi, qi, ri;
    ai = int'(a);
    bi = int'(b);
    if (bi == 0) begin
      e.q = '1;
      e.r = a[8:0];
      e.z = 1'b1;
    end else begin
      qi = ai / bi;
      ri = ai % bi;
`ifdef CNN_UDIV_ROUND_EN
      if (2 * ri >= bi) qi++;
`endif
      e.q = 15'(qi);
      e.r = 9'(ri);
      e.z = 1'b0;
    end
    return e;
  endfunction

  task automatic run_op(input logic [14:0] a, input logic [8:0] b,
                        input int gap, input int hold, input bit chain,
                        input logic [14:0] na, input logic [8:0] nb,
                        input string tag);
    res_t e;
    int   w;
    int   lat;
    repeat (gap) @(negedge ap_clk);
    @(negedge ap_clk);
    dout_rdy = 1'b0;
    din0 = a;
    din1 = b;
    din_vld = 1'b1;
    sb.push_back(model(a, b));
    w = 0;
    while (!din_rdy && w < 40) begin
      @(negedge ap_clk);
      w++;
    end
    if (g_imm) chk({tag, "_wait"}, w, 0);
    g_imm = 1'b0;
    if (!din_rdy) begin
      chk({tag, "_acc"}, 0, 1);
      din_vld = 1'b0;
      e = sb.pop_back();
      return;
    end
    @(posedge ap_clk);
    lat = 0;
    do begin
      @(negedge ap_clk);
      lat++;
      din_vld = 1'b0;
      din0 = 15'($urandom);
      din1 = 9'($urandom);
    end while (!dout_vld && lat < 40);
    chk({tag, "_lat"}, lat, (b == 0) ? 1 : RES_LAT);
    e = sb.pop_front();
    chk({tag, "_q"}, int'(quot), int'(e.q));
    chk({tag, "_r"}, int'(rem), int'(e.r));
    chk({tag, "_z"}, int'(dbz), int'(e.z));
    if (b != 0) chk({tag, "_rlt"}, int'(rem < b), 1);
    if (chain) begin
      din0 = na;
      din1 = nb;
      din_vld = 1'b1;
      g_imm = 1'b1;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge ap_clk);
      chk({tag, "_hvld"}, int'(dout_vld), 1);
      chk({tag, "_hq"}, int'(quot), int'(e.q));
      chk({tag, "_hr"}, int'(rem), int'(e.r));
      chk({tag, "_hz"}, int'(dbz), int'(e.z));
      chk({tag, "_hrdy"}, int'(din_rdy), 0);
    end
    dout_rdy = 1'b1;
    @(posedge ap_clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    logic [14:0] ra;
    logic [8:0]  rb;
    int          seen;

    repeat (2) @(negedge ap_clk);
    chk("rst_rdy", int'(din_rdy), 0);
    chk("rst_vld", int'(dout_vld), 0);
    chk("rst_q", int'(quot), 0);
    chk("rst_r", int'(rem), 0);
    chk("rst_z", int'(dbz), 0);
    ap_rst = 1'b0;
    @(negedge ap_clk);
    chk("rel_rdy", int'(din_rdy), 1);

    run_op(15'd1000, 9'd7, 0, 0, 1'b0, '0, '0, "t1");
    run_op(15'd32767, 9'd1, 0, 0, 1'b0, '0, '0, "t2a");
    run_op(15'd0, 9'd255, 1, 0, 1'b0, '0, '0, "t2b");
    run_op(15'd5, 9'd0, 0, 0, 1'b0, '0, '0, "t3a");
    run_op(15'd100, 9'd200, 0, 0, 1'b0, '0, '0, "t3b");
    run_op(15'd2000, 9'd9, 0, 5, 1'b1, 15'd300, 9'd17, "t4a");
    run_op(15'd300, 9'd17, 0, 0, 1'b0, '0, '0, "t4b");

    @(negedge ap_clk);
    dout_rdy = 1'b0;
    din0 = 15'd1000;
    din1 = 9'd7;
    din_vld = 1'b1;
    chk("t5_rdy", int'(din_rdy), 1);
    @(posedge ap_clk);
    repeat (8) begin
      @(negedge ap_clk);
      din_vld = 1'b0;
    end
    ap_rst = 1'b1;
    @(negedge ap_clk);
    chk("t5_rst_rdy", int'(din_rdy), 0);
    chk("t5_rst_vld", int'(dout_vld), 0);
    chk("t5_rst_q", int'(quot), 0);
    chk("t5_rst_r", int'(rem), 0);
    chk("t5_rst_z", int'(dbz), 0);
    ap_rst = 1'b0;
    dout_rdy = 1'b1;
    seen = 0;
    repeat (25) begin
      @(negedge ap_clk);
      if (dout_vld) seen = 1;
    end
    chk("t5_no_vld", seen, 0);
    chk("t5_rel_rdy", int'(din_rdy), 1);
    chk("t5_rel_q", int'(quot), 0);
    run_op(15'd60, 9'd4, 0, 0, 1'b0, '0, '0, "t5b");

    for (int k = 0; k < 1500; k++) begin
      ra = 15'($urandom);
      if ($urandom_range(0, 15) == 0) rb = 9'd0;
      else if ($urandom_range(0, 3) == 0) rb = 9'($urandom_range(1, 8));
      else rb = 9'($urandom);
      run_op(ra, rb, $urandom_range(0, 3), $urandom_range(0, 3),
             1'b0, '0, '0, "rnd");
    end

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
